// File: rtl/cache_pkg.sv
// Shared cache-model definitions: line geometry, trace command codes and the
// saturating counter increment used by the statistics counters.
package cache_pkg;

    localparam int LINE_OFFSET_BITS = 6;
    localparam int ADDR_W           = 32 - LINE_OFFSET_BITS;
    localparam int STAT_W           = 32;

    typedef enum logic [3:0] {
        CMD_INST_FETCH = 4'd2,
        CMD_INVALIDATE = 4'd3,
        CMD_RESET      = 4'd8,
        CMD_PRINT      = 4'd9
    } trace_cmd_e;

    // Statistics stick at all-ones instead of wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == {STAT_W{1'b1}}) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/ins_fill_queue.sv
// In-order line-fill request queue from the I-cache to the next level, with
// duplicate suppression against pending entries and request/coalesce/drop stats.
module ins_fill_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int CNT_W  = cache_pkg::STAT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       req_valid,
    input  logic [ADDR_W-1:0]          req_addr,
    output logic                       out_valid,
    output logic [ADDR_W-1:0]          out_addr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           fill_count,
    output logic [CNT_W-1:0]           coalesce_count,
    output logic [CNT_W-1:0]           drop_count
);
    import cache_pkg::sat_inc;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [ADDR_W-1:0] entry_reg [DEPTH];
    logic [DEPTH-1:0]  valid_reg;
    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [OCC_W-1:0]  occ_reg, occ_next;
    logic [CNT_W-1:0]  fill_reg, fill_next;
    logic [CNT_W-1:0]  coal_reg, coal_next;
    logic [CNT_W-1:0]  drop_reg, drop_next;

    logic [DEPTH-1:0]  hit;
    logic              deq, match, space, enq, drop;

    // Compare against registered valid bits, so a head leaving this cycle
    // still absorbs a matching request.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign hit[gi] = valid_reg[gi] && (entry_reg[gi] == req_addr);
    end

    always_comb begin
        deq       = (occ_reg != '0) && out_ready;
        match     = req_valid && (|hit);
        space     = (occ_reg != OCC_W'(DEPTH)) || deq;
        enq       = req_valid && !match && space;
        drop      = req_valid && !match && !space;

        occ_next  = occ_reg;
        if (enq && !deq)
            occ_next = occ_reg + OCC_W'(1);
        else if (deq && !enq)
            occ_next = occ_reg - OCC_W'(1);

        fill_next = enq   ? sat_inc(fill_reg) : fill_reg;
        coal_next = match ? sat_inc(coal_reg) : coal_reg;
        drop_next = drop  ? sat_inc(drop_reg) : drop_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                entry_reg[i] <= '0;
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            occ_reg   <= '0;
            fill_reg  <= '0;
            coal_reg  <= '0;
            drop_reg  <= '0;
        end else if (flush) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            occ_reg   <= '0;
            fill_reg  <= '0;
            coal_reg  <= '0;
            drop_reg  <= '0;
        end else begin
            if (deq) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
            end
            // When full with a dequeue, tail equals head: the set below wins.
            if (enq) begin
                entry_reg[tail_reg] <= req_addr;
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
            occ_reg  <= occ_next;
            fill_reg <= fill_next;
            coal_reg <= coal_next;
            drop_reg <= drop_next;
        end
    end

    assign out_valid      = (occ_reg != '0);
    assign out_addr       = entry_reg[head_reg];
    assign occupancy      = occ_reg;
    assign fill_count     = fill_reg;
    assign coalesce_count = coal_reg;
    assign drop_count     = drop_reg;

endmodule

// File: tb/tb_ins_fill_queue.sv
// Bench for ins_fill_queue: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_ins_fill_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic [25:0] req_addr = '0;
    logic        out_valid;
    logic [25:0] out_addr;
    logic        out_ready = 1'b0;
    logic [2:0]  occupancy;
    logic [31:0] fill_count, coalesce_count, drop_count;

    int vectors = 0;
    int miscompares = 0;

    logic [25:0] mq[$];
    logic [31:0] m_fill = 0, m_coal = 0, m_drop = 0;

    ins_fill_queue #(.DEPTH(DEPTH), .ADDR_W(26), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr),
        .out_valid(out_valid), .out_addr(out_addr), .out_ready(out_ready),
        .occupancy(occupancy), .fill_count(fill_count),
        .coalesce_count(coalesce_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    function automatic bit model_has(input logic [25:0] a);
        foreach (mq[i]) if (mq[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle of inputs and advance the reference model by one clock.
    task automatic cycle(input bit rv, input logic [25:0] ra, input bit rdy, input bit fl);
        bit deq, hit, room;
        req_valid = rv; req_addr = ra; out_ready = rdy; flush = fl;
        if (fl) begin
            mq.delete(); m_fill = 0; m_coal = 0; m_drop = 0;
        end else begin
            deq  = (mq.size() != 0) && rdy;
            hit  = rv && model_has(ra);
            room = (mq.size() < DEPTH) || deq;
            if (deq) void'(mq.pop_front());
            if (rv) begin
                if (hit) m_coal = sat(m_coal);
                else if (room) begin mq.push_back(ra); m_fill = sat(m_fill); end
                else m_drop = sat(m_drop);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_addr !== 26'd0 ||
            fill_count !== 0 || coalesce_count !== 0 || drop_count !== 0) begin
            miscompares++;
            $display("FAIL reset_init: valid=%0b occ=%0d addr=%h f=%0d c=%0d d=%0d, want all 0",
                     out_valid, occupancy, out_addr, fill_count, coalesce_count, drop_count);
        end
        for (int i = 0; i < 3; i++) cycle(1, 26'h30 + 26'(i), 0, 0);
        vectors++;
        if (occupancy !== 3'd3) begin
            miscompares++; $display("FAIL reset_fill: occ=%0d want 3", occupancy);
        end
        #2 rst_n = 1'b0; #1;
        mq.delete(); m_fill = 0; m_coal = 0; m_drop = 0;
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || fill_count !== 0 ||
            coalesce_count !== 0 || drop_count !== 0) begin
            miscompares++;
            $display("FAIL reset_async: valid=%0b occ=%0d f=%0d c=%0d d=%0d, want all 0",
                     out_valid, occupancy, fill_count, coalesce_count, drop_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        cycle(0, '0, 1, 1);
        cycle(1, 26'h0ABCDEF, 1, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_addr !== 26'h0ABCDEF || fill_count !== 32'd1) begin
            miscompares++;
            $display("FAIL single: valid=%0b addr=%h fill=%0d want 1 0abcdef 1",
                     out_valid, out_addr, fill_count);
        end
        cycle(0, '0, 1, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_drain: valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_duplicate();
        cycle(0, '0, 0, 1);
        cycle(1, 26'h100, 0, 0);
        cycle(1, 26'h100, 0, 0);
        vectors++;
        if (occupancy !== 3'd1 || fill_count !== 32'd1 || coalesce_count !== 32'd1) begin
            miscompares++;
            $display("FAIL duplicate: occ=%0d fill=%0d coal=%0d want 1 1 1",
                     occupancy, fill_count, coalesce_count);
        end
    endtask

    task automatic test_full();
        cycle(0, '0, 0, 1);
        for (int i = 1; i <= 5; i++) cycle(1, 26'(i), 0, 0);
        vectors++;
        if (occupancy !== 3'd4 || drop_count !== 32'd1 || fill_count !== 32'd4) begin
            miscompares++;
            $display("FAIL full: occ=%0d drop=%0d fill=%0d want 4 1 4",
                     occupancy, drop_count, fill_count);
        end
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_addr !== 26'(i)) begin
                miscompares++;
                $display("FAIL full_order: valid=%0b addr=%h want 1 %h", out_valid, out_addr, 26'(i));
            end
            cycle(0, '0, 1, 0);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL full_empty: valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_full_deq();
        cycle(0, '0, 0, 1);
        for (int i = 1; i <= 4; i++) cycle(1, 26'(i), 0, 0);
        cycle(1, 26'h9, 1, 0);
        vectors++;
        if (occupancy !== 3'd4 || drop_count !== 32'd0 || fill_count !== 32'd5 || out_addr !== 26'h2) begin
            miscompares++;
            $display("FAIL full_deq: occ=%0d drop=%0d fill=%0d head=%h want 4 0 5 2",
                     occupancy, drop_count, fill_count, out_addr);
        end
        cycle(1, 26'h2, 1, 0);
        vectors++;
        if (coalesce_count !== 32'd1 || occupancy !== 3'd3 || out_addr !== 26'h3) begin
            miscompares++;
            $display("FAIL departing_head: coal=%0d occ=%0d head=%h want 1 3 3",
                     coalesce_count, occupancy, out_addr);
        end
    endtask

    task automatic test_backpressure();
        cycle(0, '0, 0, 1);
        cycle(1, 26'h77, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(i < 3, 26'h80 + 26'(i), 0, 0);
            vectors++;
            if (out_valid !== 1'b1 || out_addr !== 26'h77) begin
                miscompares++;
                $display("FAIL backpressure: cyc=%0d valid=%0b addr=%h want 1 77", i, out_valid, out_addr);
            end
        end
    endtask

    task automatic test_wrap();
        cycle(0, '0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            cycle(1, 26'h200 + 26'(i), 1, 0);
            vectors++;
            if (out_valid !== 1'b1 || out_addr !== 26'h200 + 26'(i) || occupancy !== 3'd1) begin
                miscompares++;
                $display("FAIL wrap: step=%0d valid=%0b addr=%h occ=%0d want 1 %h 1",
                         i, out_valid, out_addr, occupancy, 26'h200 + 26'(i));
            end
        end
        cycle(1, 26'h300, 0, 0);
        cycle(1, 26'h301, 0, 0);
        cycle(1, 26'h302, 1, 1);
        vectors++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || fill_count !== 0 ||
            coalesce_count !== 0 || drop_count !== 0) begin
            miscompares++;
            $display("FAIL flush: valid=%0b occ=%0d f=%0d c=%0d d=%0d want all 0",
                     out_valid, occupancy, fill_count, coalesce_count, drop_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, 26'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);
            vectors++;
            if (out_valid !== (mq.size() != 0) || occupancy !== 3'(mq.size()) ||
                (mq.size() != 0 && out_addr !== mq[0]) ||
                fill_count !== m_fill || coalesce_count !== m_coal || drop_count !== m_drop) begin
                miscompares++;
                $display("FAIL random: n=%0d valid=%0b occ=%0d addr=%h f=%0d c=%0d d=%0d want occ=%0d head=%h f=%0d c=%0d d=%0d",
                         n, out_valid, occupancy, out_addr, fill_count, coalesce_count, drop_count,
                         mq.size(), (mq.size() != 0) ? mq[0] : 26'd0, m_fill, m_coal, m_drop);
            end
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_duplicate();
        test_full();
        test_full_deq();
        test_backpressure();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
